// File: rtl/game_pkg.sv
// Shared types and helpers for the turn sequencer: FSM state encoding,
// cell codes and packed-board cell extraction.
package game_pkg;

   typedef enum logic [1:0] {
      START  = 2'd0,
      TURN   = 2'd1,
      COMMIT = 2'd2,
      END    = 2'd3
   } gstate_t;

   localparam int EMPTY = 0;

   // Widest packed board the extraction helper handles (CELLS*CW).
   localparam int MAX_BOARD_W = 256;

   function automatic logic [7:0] cell_code(input logic [7:0] p);
      return p + 8'd1;
   endfunction

   function automatic logic [7:0] cell_at(input logic [MAX_BOARD_W-1:0] board,
                                          input int unsigned idx,
                                          input int unsigned cw);
      logic [MAX_BOARD_W-1:0] shifted;
      shifted = board >> (idx * cw);
      return shifted[7:0] & ((8'd1 << cw) - 8'd1);
   endfunction

endpackage

// File: rtl/game_flop.sv
// Two-phase master/slave register with a synchronous reset mux in front:
// the master captures on ph2, the slave launches on ph1.
module game_flop #(
   parameter int           W       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         ph1,
   input  logic         ph2,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] master;

   always_ff @(posedge ph2) begin
      master <= reset ? RST_VAL : d;
   end

   always_ff @(posedge ph1) begin
      q <= master;
   end

endmodule

// File: rtl/turn_timer.sv
// Per-turn down-counter: loads TIMEOUT-1 on clear, counts while enabled and
// flags expiry at zero. TIMEOUT=0 disables expiry entirely.
module turn_timer #(
   parameter int TIMEOUT = 0
) (
   input  logic ph1,
   input  logic ph2,
   input  logic reset,
   input  logic clear,
   input  logic en,
   output logic expire
);

   localparam int            TW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] LOAD = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

   logic [TW-1:0] cnt;
   logic [TW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt;
      if (clear) begin
         cnt_d = LOAD;
      end else if (en && (cnt != '0)) begin
         cnt_d = cnt - TW'(1);
      end
   end

   game_flop #(.W(TW), .RST_VAL(LOAD)) u_cnt_ff (
      .ph1   (ph1),
      .ph2   (ph2),
      .reset (reset),
      .d     (cnt_d),
      .q     (cnt)
   );

   assign expire = (TIMEOUT != 0) && en && (cnt == '0);

endmodule

// File: rtl/game_turn_controller.sv
// N-player turn sequencer: edge-detects move requests, validates them against
// the board, issues one-cycle writes, rotates turns and enforces a turn timeout.
//
// state  | meaning
// START  | wait for an empty board, then load startPlayer
// TURN   | accept / reject requests, run the turn timer
// COMMIT | drive the board write, advance player and move count
// END    | game over, hold until newGame
module game_turn_controller
   import game_pkg::*;
#(
   parameter int NPLAYERS     = 2,
   parameter int CELLS        = 9,
   parameter int ADDRW        = 4,
   parameter int CW           = 2,
   parameter int TURN_TIMEOUT = 0
) (
   input  logic                         ph1,
   input  logic                         ph2,
   input  logic                         reset,
   input  logic [$clog2(NPLAYERS)-1:0]  startPlayer,
   input  logic                         newGame,
   input  logic                         playerWrite,
   input  logic [ADDRW-1:0]             playerInput,
   input  logic [CELLS*CW-1:0]          gBoard,
   input  logic                         gameIsDone,
   output logic                         wr,
   output logic [ADDRW-1:0]             addr,
   output logic [CW-1:0]                cellState,
   output logic [$clog2(NPLAYERS)-1:0]  curPlayer,
   output logic [$clog2(CELLS+1)-1:0]   moveCount,
   output logic                         moveRejected,
   output logic                         turnTimeout,
   output logic [1:0]                   state
);

   localparam int PW = $clog2(NPLAYERS);
   localparam int MW = $clog2(CELLS + 1);

   gstate_t          cur_state;
   gstate_t          nxt_state;
   logic [1:0]       state_q;
   logic [PW-1:0]    cur_player;
   logic [PW-1:0]    player_d;
   logic [PW-1:0]    next_player;
   logic [MW-1:0]    move_count;
   logic [MW-1:0]    count_d;
   logic [ADDRW-1:0] lat_addr;
   logic [ADDRW-1:0] lat_d;
   logic             prev_write;
   logic [CW-1:0]    cur_code;
   logic             request;
   logic             in_range;
   logic             target_empty;
   logic             valid_req;
   logic             board_empty;
   logic             timer_en;
   logic             timer_clear;
   logic             timer_expire;
   logic             timeout_fire;

   assign request      = playerWrite && !prev_write;
   assign in_range     = 32'(playerInput) < 32'(CELLS);
   assign target_empty = cell_at(MAX_BOARD_W'(gBoard), 32'(playerInput), 32'(CW)) == 8'(EMPTY);
   assign valid_req    = request && in_range && target_empty;
   assign board_empty  = (gBoard == '0);
   assign cur_code     = CW'(cell_code(8'(cur_player)));
   assign next_player  = (cur_player == PW'(NPLAYERS - 1)) ? '0 : cur_player + PW'(1);

   // A valid request always beats expiry; a rejected one does not stop it.
   assign timeout_fire = (cur_state == TURN) && !gameIsDone && !valid_req && timer_expire;
   assign timer_en     = (cur_state == TURN);
   assign timer_clear  = (cur_state != TURN) || timeout_fire;

   turn_timer #(.TIMEOUT(TURN_TIMEOUT)) u_timer (
      .ph1    (ph1),
      .ph2    (ph2),
      .reset  (reset),
      .clear  (timer_clear),
      .en     (timer_en),
      .expire (timer_expire)
   );

   game_flop #(.W(2), .RST_VAL(2'(START))) u_state_ff (
      .ph1 (ph1), .ph2 (ph2), .reset (reset), .d (2'(nxt_state)), .q (state_q)
   );
   assign cur_state = gstate_t'(state_q);

   always_comb begin
      nxt_state = cur_state;
      case (cur_state)
         START:   if (board_empty) nxt_state = TURN;
         TURN: begin
            if (gameIsDone)     nxt_state = END;
            else if (valid_req) nxt_state = COMMIT;
         end
         COMMIT:  nxt_state = TURN;
         END:     if (newGame) nxt_state = START;
         default: nxt_state = START;
      endcase
   end

   always_comb begin
      wr           = 1'b0;
      addr         = '1;
      cellState    = '0;
      moveRejected = 1'b0;
      turnTimeout  = 1'b0;
      case (cur_state)
         TURN: begin
            cellState    = cur_code;
            moveRejected = !gameIsDone && request && !valid_req;
            turnTimeout  = timeout_fire;
         end
         COMMIT: begin
            wr        = 1'b1;
            addr      = lat_addr;
            cellState = cur_code;
         end
         default: ;
      endcase
   end

   always_comb begin
      player_d = cur_player;
      count_d  = move_count;
      lat_d    = lat_addr;
      if ((cur_state == START) && board_empty) begin
         player_d = startPlayer;
         count_d  = '0;
      end
      if ((cur_state == COMMIT) || timeout_fire) begin
         player_d = next_player;
      end
      if ((cur_state == COMMIT) && (move_count != MW'(CELLS))) begin
         count_d = move_count + MW'(1);
      end
      if ((cur_state == TURN) && !gameIsDone && valid_req) begin
         lat_d = playerInput;
      end
   end

   game_flop #(.W(PW)) u_player_ff (
      .ph1 (ph1), .ph2 (ph2), .reset (reset), .d (player_d), .q (cur_player)
   );
   game_flop #(.W(MW)) u_count_ff (
      .ph1 (ph1), .ph2 (ph2), .reset (reset), .d (count_d), .q (move_count)
   );
   game_flop #(.W(ADDRW), .RST_VAL({ADDRW{1'b1}})) u_addr_ff (
      .ph1 (ph1), .ph2 (ph2), .reset (reset), .d (lat_d), .q (lat_addr)
   );
   game_flop #(.W(1)) u_edge_ff (
      .ph1 (ph1), .ph2 (ph2), .reset (reset), .d (playerWrite), .q (prev_write)
   );

   assign curPlayer = cur_player;
   assign moveCount = move_count;
   assign state     = state_q;

endmodule

// File: tb/tb_game_turn_controller.sv
// Bench for game_turn_controller (3 players, 9 cells, 8-cycle turn timeout):
// directed vector table, a timeout sequence, then random play against a model.
module tb_game_turn_controller;

   localparam int NP    = 3;
   localparam int CELLS = 9;
   localparam int ADDRW = 4;
   localparam int CW    = 2;
   localparam int TO    = 8;

   logic                      ph1, ph2, reset;
   logic [1:0]                start_player;
   logic                      new_game, player_write, game_done;
   logic [ADDRW-1:0]          player_input;
   logic [CELLS*CW-1:0]       g_board;
   logic                      wr_o, rej_o, to_o;
   logic [ADDRW-1:0]          addr_o;
   logic [CW-1:0]             cs_o;
   logic [1:0]                cur_o, st_o;
   logic [3:0]                cnt_o;

   logic [CW-1:0] board [CELLS];

   int tests = 0;
   int fails = 0;

   game_turn_controller #(
      .NPLAYERS(NP), .CELLS(CELLS), .ADDRW(ADDRW), .CW(CW), .TURN_TIMEOUT(TO)
   ) dut (
      .ph1          (ph1),
      .ph2          (ph2),
      .reset        (reset),
      .startPlayer  (start_player),
      .newGame      (new_game),
      .playerWrite  (player_write),
      .playerInput  (player_input),
      .gBoard       (g_board),
      .gameIsDone   (game_done),
      .wr           (wr_o),
      .addr         (addr_o),
      .cellState    (cs_o),
      .curPlayer    (cur_o),
      .moveCount    (cnt_o),
      .moveRejected (rej_o),
      .turnTimeout  (to_o),
      .state        (st_o)
   );

   always begin
      ph1 = 1'b1; #3;
      ph1 = 1'b0; #2;
      ph2 = 1'b1; #3;
      ph2 = 1'b0; #2;
   end

   always_comb begin
      g_board = '0;
      for (int i = 0; i < CELLS; i++) g_board[i*CW +: CW] = board[i];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input int st, input int cur, input int cnt,
                            input int wr, input int addr, input int cs, input int rej, input int to);
      chk({tag, ".state"},        32'(st_o),  st);
      chk({tag, ".curPlayer"},    32'(cur_o), cur);
      chk({tag, ".moveCount"},    32'(cnt_o), cnt);
      chk({tag, ".wr"},           32'(wr_o),  wr);
      chk({tag, ".addr"},         32'(addr_o), addr);
      chk({tag, ".cellState"},    32'(cs_o),  cs);
      chk({tag, ".moveRejected"}, 32'(rej_o), rej);
      chk({tag, ".turnTimeout"},  32'(to_o),  to);
   endtask

   task automatic clear_board();
      for (int i = 0; i < CELLS; i++) board[i] = '0;
   endtask

   task automatic drive(input int rst, input int pw, input int pin, input int done,
                        input int ng, input int sp);
      reset        = rst[0];
      player_write = pw[0];
      player_input = ADDRW'(pin);
      game_done    = done[0];
      new_game     = ng[0];
      start_player = 2'(sp);
   endtask

   // Behavioural model: phase 0..3 = START/TURN/COMMIT/END, turn age counts up.
   int m_st, m_cur, m_cnt, m_age, m_prev, m_lat;
   int e_st, e_cur, e_cnt, e_wr, e_addr, e_cs, e_rej, e_to;
   int pend_wr, pend_addr, pend_val;

   task automatic model_reset();
      m_st = 0; m_cur = 0; m_cnt = 0; m_age = 0; m_prev = 0; m_lat = 15;
   endtask

   task automatic model_step(input int rst, input int pw, input int pin, input int done,
                             input int ng, input int sp);
      int req, empty_all, ok;
      e_st = m_st; e_cur = m_cur; e_cnt = m_cnt;
      e_wr = 0; e_addr = 15; e_cs = 0; e_rej = 0; e_to = 0;
      pend_wr = 0; pend_addr = 0; pend_val = 0;
      req = (pw != 0 && m_prev == 0) ? 1 : 0;
      empty_all = 1;
      for (int i = 0; i < CELLS; i++) if (board[i] != 0) empty_all = 0;
      ok = 0;
      if (pin < CELLS) begin
         if (board[pin] == 0) ok = 1;
      end
      case (m_st)
         0: if (empty_all != 0) begin
               m_st = 1; m_cur = sp; m_cnt = 0; m_age = 0;
            end
         1: begin
            e_cs = m_cur + 1;
            if (done != 0) begin
               m_st = 3;
            end else if (req != 0 && ok != 0) begin
               m_lat = pin; m_st = 2;
            end else begin
               e_rej = req;
               if (m_age == TO - 1) begin
                  e_to = 1; m_cur = (m_cur + 1) % NP; m_age = 0;
               end else begin
                  m_age++;
               end
            end
         end
         2: begin
            e_wr = 1; e_addr = m_lat; e_cs = m_cur + 1;
            pend_wr = 1; pend_addr = m_lat; pend_val = m_cur + 1;
            m_st = 1; m_cur = (m_cur + 1) % NP; m_age = 0;
            if (m_cnt < CELLS) m_cnt++;
         end
         default: if (ng != 0) m_st = 0;
      endcase
      m_prev = pw;
      if (rst != 0) model_reset();
   endtask

   typedef struct {
      int rst, pw, pin, done, ng, sp, clr;
      int st, cur, cnt, wr, addr, cs, rej, to;
   } vec_t;

   vec_t tbl[36];
   int   r_rst, r_pw, r_pin, r_done, r_ng, r_sp;

   initial begin
      //          rst pw pin dn ng sp clr | st cur cnt wr addr cs rej to
      tbl[0]  = '{1, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 15, 0, 0, 0};
      tbl[1]  = '{0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 15, 0, 0, 0};
      tbl[2]  = '{0, 1, 4, 0, 0, 1, 0,  1, 1, 0, 0, 15, 2, 0, 0};
      tbl[3]  = '{0, 1, 4, 0, 0, 1, 0,  2, 1, 0, 1,  4, 2, 0, 0};
      tbl[4]  = '{0, 1, 4, 0, 0, 1, 0,  1, 2, 1, 0, 15, 3, 0, 0};
      tbl[5]  = '{0, 0, 4, 0, 0, 1, 0,  1, 2, 1, 0, 15, 3, 0, 0};
      tbl[6]  = '{0, 1, 4, 0, 0, 1, 0,  1, 2, 1, 0, 15, 3, 1, 0};
      tbl[7]  = '{0, 0, 4, 0, 0, 1, 0,  1, 2, 1, 0, 15, 3, 0, 0};
      tbl[8]  = '{0, 1, 9, 0, 0, 1, 0,  1, 2, 1, 0, 15, 3, 1, 0};
      tbl[9]  = '{0, 1, 9, 0, 0, 1, 0,  1, 2, 1, 0, 15, 3, 0, 0};
      tbl[10] = '{0, 0, 9, 0, 0, 1, 0,  1, 2, 1, 0, 15, 3, 0, 0};
      tbl[11] = '{0, 0, 9, 0, 0, 1, 0,  1, 2, 1, 0, 15, 3, 0, 1};
      tbl[12] = '{0, 0, 0, 0, 0, 1, 0,  1, 0, 1, 0, 15, 1, 0, 0};
      tbl[13] = '{0, 1, 0, 0, 0, 1, 0,  1, 0, 1, 0, 15, 1, 0, 0};
      tbl[14] = '{0, 1, 0, 0, 0, 1, 0,  2, 0, 1, 1,  0, 1, 0, 0};
      tbl[15] = '{0, 1, 0, 0, 0, 1, 0,  1, 1, 2, 0, 15, 2, 0, 0};
      tbl[16] = '{0, 1, 0, 0, 0, 1, 0,  1, 1, 2, 0, 15, 2, 0, 0};
      tbl[17] = '{0, 1, 0, 0, 0, 1, 0,  1, 1, 2, 0, 15, 2, 0, 0};
      tbl[18] = '{0, 0, 8, 0, 0, 1, 0,  1, 1, 2, 0, 15, 2, 0, 0};
      tbl[19] = '{0, 1, 8, 0, 0, 1, 0,  1, 1, 2, 0, 15, 2, 0, 0};
      tbl[20] = '{0, 0, 8, 0, 0, 1, 0,  2, 1, 2, 1,  8, 2, 0, 0};
      tbl[21] = '{0, 1, 3, 0, 0, 1, 0,  1, 2, 3, 0, 15, 3, 0, 0};
      tbl[22] = '{0, 0, 3, 0, 0, 1, 0,  2, 2, 3, 1,  3, 3, 0, 0};
      tbl[23] = '{0, 1, 5, 0, 0, 1, 0,  1, 0, 4, 0, 15, 1, 0, 0};
      tbl[24] = '{0, 0, 5, 0, 0, 1, 0,  2, 0, 4, 1,  5, 1, 0, 0};
      tbl[25] = '{0, 1, 6, 1, 0, 1, 0,  1, 1, 5, 0, 15, 2, 0, 0};
      tbl[26] = '{0, 0, 6, 1, 0, 1, 0,  3, 1, 5, 0, 15, 0, 0, 0};
      tbl[27] = '{0, 1, 6, 0, 0, 1, 0,  3, 1, 5, 0, 15, 0, 0, 0};
      tbl[28] = '{0, 1, 6, 0, 1, 1, 0,  3, 1, 5, 0, 15, 0, 0, 0};
      tbl[29] = '{0, 1, 6, 0, 0, 2, 0,  0, 1, 5, 0, 15, 0, 0, 0};
      tbl[30] = '{0, 1, 6, 0, 0, 2, 1,  0, 1, 5, 0, 15, 0, 0, 0};
      tbl[31] = '{0, 1, 0, 0, 0, 2, 0,  1, 2, 0, 0, 15, 3, 0, 0};
      tbl[32] = '{0, 0, 0, 0, 0, 2, 0,  1, 2, 0, 0, 15, 3, 0, 0};
      tbl[33] = '{0, 1, 7, 0, 0, 2, 0,  1, 2, 0, 0, 15, 3, 0, 0};
      tbl[34] = '{1, 0, 7, 0, 0, 2, 0,  2, 2, 0, 1,  7, 3, 0, 0};
      tbl[35] = '{0, 0, 7, 0, 0, 2, 0,  0, 0, 0, 0, 15, 0, 0, 0};

      clear_board();
      drive(1, 0, 0, 0, 0, 1);
      repeat (3) @(posedge ph1);

      for (int r = 0; r < 36; r++) begin
         @(posedge ph1); #1;
         if (tbl[r].clr != 0) clear_board();
         drive(tbl[r].rst, tbl[r].pw, tbl[r].pin, tbl[r].done, tbl[r].ng, tbl[r].sp);
         #3;
         check_all($sformatf("vec%0d", r), tbl[r].st, tbl[r].cur, tbl[r].cnt, tbl[r].wr,
                   tbl[r].addr, tbl[r].cs, tbl[r].rej, tbl[r].to);
         if (tbl[r].wr != 0) board[tbl[r].addr] = CW'(tbl[r].cs);
      end

      // Idle turns: timeout every 8th TURN cycle, player rotating 0,1,2.
      @(posedge ph1); #1;
      clear_board();
      drive(0, 0, 0, 0, 0, 0);
      #3;
      chk("idle.start_state", 32'(st_o), 0);
      for (int k = 1; k <= 24; k++) begin
         @(posedge ph1); #4;
         chk($sformatf("idle%0d.state", k), 32'(st_o), 1);
         chk($sformatf("idle%0d.turnTimeout", k), 32'(to_o), (k % 8 == 0) ? 1 : 0);
         chk($sformatf("idle%0d.curPlayer", k), 32'(cur_o), ((k - 1) / 8) % 3);
      end

      @(posedge ph1); #1;
      drive(1, 0, 0, 0, 0, 0);
      clear_board();
      repeat (2) @(posedge ph1);
      model_reset();
      r_pw = 0;

      for (int c = 0; c < 3000; c++) begin
         @(posedge ph1); #1;
         if (m_st == 0 && $urandom_range(0, 1) == 0) clear_board();
         r_rst  = ($urandom_range(0, 299) == 0) ? 1 : 0;
         if ($urandom_range(0, 3) == 0) r_pw = (r_pw == 0) ? 1 : 0;
         r_pin  = $urandom_range(0, 15);
         r_done = ((m_cnt >= 6 && $urandom_range(0, 3) == 0) || $urandom_range(0, 49) == 0) ? 1 : 0;
         r_ng   = ($urandom_range(0, 2) == 0) ? 1 : 0;
         r_sp   = $urandom_range(0, 2);
         drive(r_rst, r_pw, r_pin, r_done, r_ng, r_sp);
         model_step(r_rst, r_pw, r_pin, r_done, r_ng, r_sp);
         #3;
         check_all($sformatf("rnd%0d", c), e_st, e_cur, e_cnt, e_wr, e_addr, e_cs, e_rej, e_to);
         if (pend_wr != 0) board[pend_addr] = CW'(pend_val);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
